// File: rtl/serial_src_pkg.sv
// Shared types and helpers for the serial pattern source.
// Optional build macro: SERIAL_SRC_LOOP_EN (continuous replay of the held pattern).
package serial_src_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReady,
      StShift,
      StDone
   } state_e;

   // Divider counter width; never narrower than one bit, even for DIV of 1 or 2.
   function automatic int unsigned div_w(input int unsigned div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector whose history flop resets high, so a level that is
// already high when reset releases is not reported as an edge.
module edge_rise (
   input  logic clock,
   input  logic resetn,
   input  logic level,
   output logic pulse
);

   logic hist_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) hist_q <= 1'b1;
      else         hist_q <= level;
   end

   assign pulse = level & ~hist_q;

endmodule

// File: rtl/serial_pattern_source.sv
// Captures a parallel pattern and shifts it out MSB-first, one bit every DIV clocks.
// Optional build macro: SERIAL_SRC_LOOP_EN (replay the held pattern until aborted).
module serial_pattern_source
   import serial_src_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 4
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic                       load,
   input  logic                       start,
   input  logic [WIDTH-1:0]           pattern,
   output logic                       w_out,
   output logic                       w_valid,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(WIDTH)-1:0]   bit_idx
);

   localparam int unsigned DivW = div_w(DIV);
   localparam int unsigned IdxW = $clog2(WIDTH);
   localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);
   localparam logic [IdxW-1:0] IdxMax = IdxW'(WIDTH - 1);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  hold_q, hold_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic [DivW-1:0]   div_q, div_d, div_next;
   logic [IdxW-1:0]   idx_q, idx_d, idx_cur;
   logic              w_out_q, w_out_d;
   logic              w_valid_q, w_valid_d;
   logic              done_q, done_d;
   logic              load_edge, start_edge;
   logic              run;
   logic [WIDTH-1:0]  run_src;

   edge_rise u_load_edge (
      .clock  (clock),
      .resetn (resetn),
      .level  (load),
      .pulse  (load_edge)
   );

   edge_rise u_start_edge (
      .clock  (clock),
      .resetn (resetn),
      .level  (start),
      .pulse  (start_edge)
   );

   // The strobe is registered, so a bit is emitted on the edge whose next
   // divider value is DIV-1; w_valid then coincides with that count.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      shreg_d   = shreg_q;
      div_d     = div_q;
      idx_d     = idx_q;
      w_out_d   = w_out_q;
      w_valid_d = 1'b0;
      done_d    = 1'b0;
      run       = 1'b0;
      run_src   = shreg_q;
      idx_cur   = idx_q;
      div_next  = (div_q == DivMax) ? '0 : div_q + DivW'(1);

      unique case (state_q)
         StIdle: begin
            if (load_edge) begin
               hold_d  = pattern;
               shreg_d = pattern;
               state_d = StReady;
            end
         end
         StReady: begin
            if (start_edge) begin
               state_d  = StShift;
               run      = 1'b1;
               run_src  = hold_q;
               div_next = '0;
               idx_cur  = '0;
            end else if (load_edge) begin
               hold_d  = pattern;
               shreg_d = pattern;
            end
         end
         StShift: begin
            if (start_edge) begin
               state_d = StReady;
               w_out_d = 1'b0;
               idx_d   = '0;
               div_d   = '0;
`ifndef SERIAL_SRC_LOOP_EN
            end else if (w_valid_q && idx_q == '0) begin
               state_d = StDone;
               done_d  = 1'b1;
`endif
            end else begin
               run = 1'b1;
            end
         end
         StDone: begin
            state_d = StReady;
         end
         default: state_d = StIdle;
      endcase

      if (run) begin
         div_d   = div_next;
         shreg_d = run_src;
         idx_d   = idx_cur;
         if (div_next == DivMax) begin
            w_valid_d = 1'b1;
            w_out_d   = run_src[WIDTH-1];
            shreg_d   = run_src << 1;
            idx_d     = (idx_cur == IdxMax) ? '0 : idx_cur + IdxW'(1);
`ifdef SERIAL_SRC_LOOP_EN
            if (idx_cur == IdxMax) begin
               shreg_d = hold_q;
               done_d  = 1'b1;
            end
`endif
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= StIdle;
         hold_q    <= '0;
         shreg_q   <= '0;
         div_q     <= '0;
         idx_q     <= '0;
         w_out_q   <= 1'b0;
         w_valid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         shreg_q   <= shreg_d;
         div_q     <= div_d;
         idx_q     <= idx_d;
         w_out_q   <= w_out_d;
         w_valid_q <= w_valid_d;
         done_q    <= done_d;
      end
   end

   assign w_out   = w_out_q;
   assign w_valid = w_valid_q;
   assign done    = done_q;
   assign busy    = (state_q == StShift);
   assign bit_idx = idx_q;

endmodule

// File: tb/tb_serial_pattern_source.sv
// Bench for serial_pattern_source: WIDTH=8 with DIV=4 and DIV=1 instances.
module tb_serial_pattern_source;

   typedef struct {
      int         cyc;
      logic       b;
      logic [2:0] idx;
   } exp_t;

   typedef struct {
      logic [7:0] pat;
      bit         do_load;
      bit         mid;
      bit         sim;
      logic [7:0] exp;
   } vec_t;

   logic       clock = 1'b0;
   logic       resetn;
   logic       load, start, load1, start1;
   logic [7:0] pattern;
   logic       w_out4, w_valid4, busy4, done4;
   logic [2:0] bit_idx4;
   logic       w_out1, w_valid1, busy1, done1;
   logic [2:0] bit_idx1;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t q4[$];
   exp_t q1[$];
   int   dq4[$];
   int   dq1[$];
   vec_t vecs[7];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   serial_pattern_source #(.WIDTH(8), .DIV(4)) dut4 (
      .clock   (clock),
      .resetn  (resetn),
      .load    (load),
      .start   (start),
      .pattern (pattern),
      .w_out   (w_out4),
      .w_valid (w_valid4),
      .busy    (busy4),
      .done    (done4),
      .bit_idx (bit_idx4)
   );

   serial_pattern_source #(.WIDTH(8), .DIV(1)) dut1 (
      .clock   (clock),
      .resetn  (resetn),
      .load    (load1),
      .start   (start1),
      .pattern (pattern),
      .w_out   (w_out1),
      .w_valid (w_valid1),
      .busy    (busy1),
      .done    (done1),
      .bit_idx (bit_idx1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s at cycle %0d: got pulse, expected none", name, cyc);
   endtask

   // Scoreboards: every strobe and done pulse must match a queued expectation.
   always @(negedge clock) begin
      if (resetn === 1'b1) begin
         if (w_valid4) begin
            if (q4.size() == 0) unexpected("w_valid4");
            else begin
               exp_t e;
               e = q4.pop_front();
               check("w_valid4 cycle", cyc, e.cyc);
               check("w_out4", w_out4, e.b);
               check("bit_idx4", bit_idx4, e.idx);
            end
         end
         if (done4) begin
            if (dq4.size() == 0) unexpected("done4");
            else check("done4 cycle", cyc, dq4.pop_front());
         end
         if (w_valid1) begin
            if (q1.size() == 0) unexpected("w_valid1");
            else begin
               exp_t e;
               e = q1.pop_front();
               check("w_valid1 cycle", cyc, e.cyc);
               check("w_out1", w_out1, e.b);
               check("bit_idx1", bit_idx1, e.idx);
            end
         end
         if (done1) begin
            if (dq1.size() == 0) unexpected("done1");
            else check("done1 cycle", cyc, dq1.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic load_pat(input logic [7:0] p);
      pattern = p;
      load    = 1'b1;
      tick(1);
      load = 1'b0;
      tick(1);
   endtask

   task automatic run4(input logic [7:0] exp, input bit mid, input bit sim, input logic [7:0] sp);
      int n;
      start = 1'b1;
      if (sim) begin
         pattern = sp;
         load    = 1'b1;
      end
      n = cyc;
      for (int k = 0; k < 8; k++) q4.push_back('{n + (k + 1) * 4, exp[7-k], 3'((k + 1) % 8)});
      dq4.push_back(n + 33);
      tick(1);
      start = 1'b0;
      load  = 1'b0;
      check("busy4 at N+1", busy4, 1);
      if (mid) begin
         wait_until(n + 10);
         pattern = 8'hFF;
         load    = 1'b1;
         tick(1);
         load = 1'b0;
      end
      wait_until(n + 32);
      check("busy4 at T", busy4, 1);
      tick(1);
      check("busy4 at T+1", busy4, 0);
      wait_until(n + 36);
   endtask

   // Reset asserted after the second bit of a run; outputs must clear at once.
   task automatic reset_mid_run(input logic [7:0] p);
      int n;
      start = 1'b1;
      n = cyc;
      for (int k = 0; k < 2; k++) q4.push_back('{n + (k + 1) * 4, p[7-k], 3'(k + 1)});
      tick(1);
      start = 1'b0;
      wait_until(n + 10);
      check("w_out4 before reset", w_out4, p[6]);
      check("bit_idx4 before reset", bit_idx4, 2);
      #2 resetn = 1'b0;
      #1;
      check("busy4 async reset", busy4, 0);
      check("w_out4 async reset", w_out4, 0);
      check("bit_idx4 async reset", bit_idx4, 0);
      check("w_valid4 async reset", w_valid4, 0);
      check("done4 async reset", done4, 0);
      tick(1);
      resetn = 1'b1;
      tick(40);
      check("busy4 after reset", busy4, 0);
   endtask

   initial begin
      vecs[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C};
      vecs[1] = '{8'hD0, 1'b1, 1'b0, 1'b0, 8'hD0};
      vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'hD0};
      vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'hD0};
      vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'hD0};
      vecs[5] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hD0};
      vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'hD0};

      resetn  = 1'b0;
      start   = 1'b1;
      load    = 1'b0;
      start1  = 1'b0;
      load1   = 1'b0;
      pattern = 8'h00;
      tick(2);
      check("reset busy", busy4, 0);
      check("reset w_out", w_out4, 0);
      check("reset w_valid", w_valid4, 0);
      check("reset done", done4, 0);
      check("reset bit_idx", bit_idx4, 0);
      resetn = 1'b1;
      tick(3);
      check("start held through reset", busy4, 0);
      start = 1'b0;
      tick(1);

`ifdef SERIAL_SRC_LOOP_EN
      begin
         int         n;
         logic [7:0] p;
         p = 8'hF0;
         load_pat(p);
         start = 1'b1;
         n = cyc;
         for (int k = 0; k < 24; k++)
            q4.push_back('{n + (k + 1) * 4, p[7 - (k % 8)], 3'((k + 1) % 8)});
         dq4.push_back(n + 32);
         dq4.push_back(n + 64);
         dq4.push_back(n + 96);
         tick(1);
         start = 1'b0;
         wait_until(n + 98);
         start = 1'b1;
         tick(1);
         start = 1'b0;
         check("loop abort busy", busy4, 0);
         check("loop abort w_out", w_out4, 0);
         check("loop abort bit_idx", bit_idx4, 0);
         tick(20);
         reset_mid_run(p);
      end
`else
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].do_load) load_pat(vecs[i].pat);
         run4(vecs[i].exp, vecs[i].mid, vecs[i].sim, vecs[i].pat);
      end

      // Abort of a D0 run after its second bit.
      begin
         int         n;
         logic [7:0] p;
         p = 8'hD0;
         start = 1'b1;
         n = cyc;
         for (int k = 0; k < 2; k++) q4.push_back('{n + (k + 1) * 4, p[7-k], 3'(k + 1)});
         tick(1);
         start = 1'b0;
         wait_until(n + 10);
         check("w_out4 before abort", w_out4, 1);
         start = 1'b1;
         tick(1);
         start = 1'b0;
         check("abort busy", busy4, 0);
         check("abort w_out", w_out4, 0);
         check("abort bit_idx", bit_idx4, 0);
         wait_until(n + 45);
      end
      run4(8'hD0, 1'b0, 1'b0, 8'h00);

      // DIV=1: one bit per clock.
      begin
         int         n;
         logic [7:0] p;
         p = 8'h96;
         pattern = p;
         load1   = 1'b1;
         tick(1);
         load1 = 1'b0;
         tick(1);
         start1 = 1'b1;
         n = cyc;
         for (int k = 0; k < 8; k++) q1.push_back('{n + k + 1, p[7-k], 3'((k + 1) % 8)});
         dq1.push_back(n + 9);
         tick(1);
         start1 = 1'b0;
         check("busy1 at N+1", busy1, 1);
         wait_until(n + 8);
         check("busy1 at N+8", busy1, 1);
         tick(1);
         check("busy1 at N+9", busy1, 0);
         tick(4);
      end

      reset_mid_run(8'hD0);
`endif

      check("strobes pending dut4", q4.size(), 0);
      check("done pending dut4", dq4.size(), 0);
      check("strobes pending dut1", q1.size(), 0);
      check("done pending dut1", dq1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
